hm2_bus_arbiter: RTL and testbench
==================================

Name: hm2_bus_arbiter

Overview:
- Shares the single HostMot2 register bus (AddrWidth=16, BusWidth=32 from the board package) between two requesters.
- Requester 0 is the HPS/Avalon-MM bridge; requester 1 is an auxiliary master (JTAG-to-Avalon debug or on-chip sequencer).
- Serialises one transaction at a time, drives the hm2 read/write strobes and returns read data with a per-requester acknowledge.
- Sits between the bus bridges and the hostmot2 top.

Parameters:
- AddrWidth, 16, HostMot2 register address width
- BusWidth, 32, data width
- ReadLatency, 2, cycles from hm2_read strobe to valid hm2_rdata (range 1..7)

Ports:
- clk  in  1  single system clock (hm2 clklow domain)
- reset  in  1  asynchronous, active-high reset
- req  in  2  per-requester request; held until the matching ack
- we  in  2  per-requester write enable (1=write, 0=read)
- addr  in  2*AddrWidth  per-requester address, packed {addr1,addr0}
- wdata  in  2*BusWidth  per-requester write data, packed
- ack  out  2  one-cycle completion pulse to the owning requester
- rdata  out  BusWidth  read data; valid while ack is high
- busy  out  1  high in any state other than IDLE
- hm2_addr  out  AddrWidth  address to HostMot2
- hm2_wdata  out  BusWidth  write data to HostMot2
- hm2_read  out  1  read strobe, exactly one cycle per read
- hm2_write  out  1  write strobe, exactly one cycle per write
- hm2_rdata  in  BusWidth  HostMot2 read data

Behaviour:
- Reset:
  - state=IDLE; all outputs 0, including ack, strobes, busy, hm2_addr, hm2_wdata and rdata.
  - Round-robin pointer set to last=1, so requester 0 wins the first tie.
- States: IDLE, WR, RD_WAIT, ACK.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not `last`.
  - On grant: register owner, we, addr and wdata of the owner; set last=owner; go to WR if we=1, else RD_WAIT.
- WR:
  - hm2_write=1 for this cycle only, with the registered addr/wdata on hm2_addr/hm2_wdata.
  - Go to ACK.
- RD_WAIT:
  - hm2_read=1 on the first cycle only.
  - A 3-bit counter runs from 1 to ReadLatency.
  - When the counter equals ReadLatency, capture hm2_rdata into rdata and go to ACK.
- ACK:
  - ack[owner]=1 for one cycle; rdata is held (reads) or 0 (writes).
  - Go to IDLE.
- Latency, with req sampled in IDLE at cycle 0:
  - Write: strobe at cycle 1, ack at cycle 2.
  - Read: strobe at cycle 1, capture at cycle ReadLatency, ack at cycle ReadLatency+1. Minimum issue interval is ReadLatency+2 cycles.
- hm2_addr and hm2_wdata hold their last values between transactions. Only the strobes qualify them.
- Back-to-back: a requester whose req stays high after its ack is treated as a new request in the next IDLE cycle.
  - With both requesting continuously, grants strictly alternate 0,1,0,1.
- Requester drops req mid-transaction: the transaction completes and ack is still pulsed. The arbiter never aborts a strobe.
- Inputs of the non-owner are ignored while busy.
- Asynchronous reset mid-transaction: the state machine returns to IDLE immediately and no further strobe or ack is issued. A read in flight on hm2 is discarded.

Optional Feature:
- Macro: HM2_ARB_LOCK_EN
- With the macro defined:
  - Extra input lock [2]. If lock[owner] is high during ACK, the arbiter enters locked mode.
  - In locked mode, IDLE grants only the owner; the other req waits.
  - Locked mode ends in IDLE when lock[owner] is low or req[owner] is low, and normal round-robin resumes.
  - Reset clears locked mode.
  - Purpose: atomic multi-register sequences such as a 64-bit timestamp read.
- Without the macro: the lock port is absent and arbitration is pure round-robin.

Decomposition:
- Package hm2_arb_pkg holds:
  - state enum {IDLE, WR, RD_WAIT, ACK};
  - requester index typedef (1 bit);
  - constants REQ_HOST=0 and REQ_AUX=1.
- Address and data widths are imported from boardtype.
- One sub-module, rr_arb2: a combinational 2-way round-robin picker taking inputs req[1:0] and last, and producing outputs gnt_valid and gnt_idx.

Test Plan:
- Single write: req[0]=1, we=1, addr=0x0100, wdata=0xDEADBEEF → hm2_write pulse at cycle 1 with those values; ack[0] at cycle 2; ack[1] never asserted.
- Single read, ReadLatency=2: req[1]=1, we=0, addr=0x0200, model returns 0x12345678 two cycles after the strobe → one hm2_read pulse; ack[1] at cycle 3 with rdata=0x12345678.
- Tie after reset: both req high (reads) → requester 0 served first, then 1; with 6 continuous transactions the grant order is 0,1,0,1,0,1 and each strobe is exactly one cycle.
- Dropped request: req[0] pulses high for 1 cycle only (write) → strobe still issued and ack[0] still pulses; arbiter returns to IDLE.
- Reset asserted in RD_WAIT → busy, strobes and ack go to 0 asynchronously; after release, the first tie is granted to requester 0.
- HM2_ARB_LOCK_EN: requester 1 holds lock with 3 reads while req[0] is high → three consecutive grants to 1, then 0 is granted on the IDLE cycle after lock[1] falls.

Source files
------------

// File: rtl/hm2_arb_pkg.sv
// Shared types and constants for the HostMot2 register-bus arbiter.
package hm2_arb_pkg;

  localparam int unsigned HM2_ADDR_W = 16;
  localparam int unsigned HM2_BUS_W  = 32;

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, ACK} arb_state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_HOST = 1'b0;
  localparam req_idx_t REQ_AUX  = 1'b1;

  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return (idx == REQ_AUX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/hm2_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_arb2
  import hm2_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_idx_t   i_last,
  output logic       o_gnt_valid_c,
  output req_idx_t   o_gnt_idx_c
);

  always_comb begin
    o_gnt_valid_c = |i_req;
    o_gnt_idx_c   = REQ_HOST;
    case (i_req)
      2'b01:   o_gnt_idx_c = REQ_HOST;
      2'b10:   o_gnt_idx_c = REQ_AUX;
      2'b11:   o_gnt_idx_c = (i_last == REQ_HOST) ? REQ_AUX : REQ_HOST;
      default: o_gnt_idx_c = REQ_HOST;
    endcase
  end

endmodule

// File: rtl/hm2_bus_arbiter.sv
// Serialises two requesters onto the single HostMot2 register bus, one transaction at a time.
// Optional HM2_ARB_LOCK_EN adds i_lock[1:0] to keep the bus with one owner for atomic sequences.
module hm2_bus_arbiter
  import hm2_arb_pkg::*;
#(
  parameter int unsigned AddrWidth   = HM2_ADDR_W,
  parameter int unsigned BusWidth    = HM2_BUS_W,
  parameter int unsigned ReadLatency = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [1:0]              i_req,
  input  logic [1:0]              i_we,
  input  logic [2*AddrWidth-1:0]  i_addr,
  input  logic [2*BusWidth-1:0]   i_wdata,
`ifdef HM2_ARB_LOCK_EN
  input  logic [1:0]              i_lock,
`endif
  output logic [1:0]              o_ack,
  output logic [BusWidth-1:0]     o_rdata,
  output logic                    o_busy,
  output logic [AddrWidth-1:0]    o_hm2_addr,
  output logic [BusWidth-1:0]     o_hm2_wdata,
  output logic                    o_hm2_read,
  output logic                    o_hm2_write,
  input  logic [BusWidth-1:0]     i_hm2_rdata
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  req_idx_t              r_owner;
  req_idx_t              r_last;
  logic [2:0]            r_cnt;
  logic [AddrWidth-1:0]  r_addr;
  logic [BusWidth-1:0]   r_wdata;
  logic [BusWidth-1:0]   r_rdata;
  logic [1:0]            r_ack;
  logic                  r_busy;
  logic                  r_read;
  logic                  r_write;

  logic [1:0]            w_req_eff;
  logic                  w_gnt_valid;
  req_idx_t              w_gnt_idx;
  logic                  w_gnt_we;
  logic [AddrWidth-1:0]  w_gnt_addr;
  logic [BusWidth-1:0]   w_gnt_wdata;
  logic                  w_grant;
  logic                  w_cnt_done;

`ifdef HM2_ARB_LOCK_EN
  logic r_locked;
  logic w_locked_nxt;

  // Locked mode restricts IDLE to the previous owner while it keeps both req and lock high.
  always_comb begin
    w_req_eff    = i_req;
    w_locked_nxt = r_locked;
    if (r_state == IDLE) begin
      if (r_locked && i_lock[r_owner] && i_req[r_owner]) begin
        w_req_eff = idx_onehot(r_owner);
      end else begin
        w_locked_nxt = 1'b0;
      end
    end else if ((r_state == ACK) && i_lock[r_owner]) begin
      w_locked_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_locked <= 1'b0;
    else         r_locked <= w_locked_nxt;
  end
`else
  assign w_req_eff = i_req;
`endif

  rr_arb2 u_rr_arb2 (
    .i_req         (w_req_eff),
    .i_last        (r_last),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_idx_c   (w_gnt_idx)
  );

  assign w_gnt_we    = i_we[w_gnt_idx];
  assign w_gnt_addr  = (w_gnt_idx == REQ_AUX) ? i_addr[2*AddrWidth-1:AddrWidth] : i_addr[AddrWidth-1:0];
  assign w_gnt_wdata = (w_gnt_idx == REQ_AUX) ? i_wdata[2*BusWidth-1:BusWidth] : i_wdata[BusWidth-1:0];
  assign w_cnt_done  = (r_cnt == 3'(ReadLatency));

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = w_gnt_we ? WR : RD_WAIT;
        end
      end
      WR:      w_state_nxt = ACK;
      RD_WAIT: if (w_cnt_done) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes and ack line up with the state they describe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_owner <= REQ_HOST;
      r_last  <= REQ_AUX;
      r_cnt   <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 2'b00;
      r_busy  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_write <= w_grant && w_gnt_we;
      r_read  <= w_grant && !w_gnt_we;
      r_ack   <= (w_state_nxt == ACK) ? idx_onehot(r_owner) : 2'b00;
      if (w_grant) begin
        r_owner <= w_gnt_idx;
        r_last  <= w_gnt_idx;
        r_addr  <= w_gnt_addr;
        r_wdata <= w_gnt_wdata;
        r_cnt   <= 3'd1;
        if (w_gnt_we) r_rdata <= '0;
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt + 3'd1;
        if (w_cnt_done) r_rdata <= i_hm2_rdata;
      end
    end
  end

  assign o_ack       = r_ack;
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;
  assign o_hm2_addr  = r_addr;
  assign o_hm2_wdata = r_wdata;
  assign o_hm2_read  = r_read;
  assign o_hm2_write = r_write;

endmodule

// File: tb/tb_hm2_bus_arbiter.sv
// Bench for hm2_bus_arbiter: transaction-timeline model checked every cycle, directed cases plus random traffic.
module tb_hm2_bus_arbiter;
  import hm2_arb_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 32;
  localparam int unsigned RL = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req = 2'b00;
  logic [1:0]      we = 2'b00;
  logic [2*AW-1:0] addr = '0;
  logic [2*BW-1:0] wdata = '0;
  logic [BW-1:0]   hm2_rdata = '0;
`ifdef HM2_ARB_LOCK_EN
  logic [1:0]      lock = 2'b00;
`endif
  logic [1:0]      ack;
  logic [BW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   hm2_addr;
  logic [BW-1:0]   hm2_wdata;
  logic            hm2_read;
  logic            hm2_write;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hm2_bus_arbiter #(.AddrWidth(AW), .BusWidth(BW), .ReadLatency(RL)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
`ifdef HM2_ARB_LOCK_EN
    .i_lock      (lock),
`endif
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_busy      (busy),
    .o_hm2_addr  (hm2_addr),
    .o_hm2_wdata (hm2_wdata),
    .o_hm2_read  (hm2_read),
    .o_hm2_write (hm2_write),
    .i_hm2_rdata (hm2_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each granted transaction is a timeline (grant cycle, strobe = grant+1, ack = last cycle).
  int unsigned cyc = 0;
  int unsigned m_start = 0;
  int unsigned m_end = 0;
  logic        m_owner = 1'b0;
  logic        m_last = 1'b1;
  logic        m_we = 1'b1;
  logic        m_locked = 1'b0;
  logic        mw;
  logic [AW-1:0] m_addr = '0;
  logic [BW-1:0] m_wdata = '0;
  logic [BW-1:0] m_rdval = '0;
  logic        fix_rd = 1'b0;
  logic [BW-1:0] fix_val = '0;
  int unsigned s_cnt = 0;
  logic        e_strobe;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_strobes", 64'({hm2_read, hm2_write}), 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_hm2_addr", 64'(hm2_addr), 64'd0);
      check("rst_hm2_wdata", 64'(hm2_wdata), 64'd0);
      m_start  = cyc - 4;
      m_end    = cyc;
      m_last   = 1'b1;
      m_locked = 1'b0;
      m_we     = 1'b1;
      m_addr   = '0;
      m_wdata  = '0;
      s_cnt    = 0;
    end else begin
      e_strobe = (cyc == m_start + 1);
      check("busy", 64'(busy), 64'((cyc > m_start) && (cyc <= m_end)));
      check("hm2_write", 64'(hm2_write), 64'(e_strobe && m_we));
      check("hm2_read", 64'(hm2_read), 64'(e_strobe && !m_we));
      check("ack", 64'(ack), (cyc == m_end) ? (m_owner ? 64'd2 : 64'd1) : 64'd0);
      check("hm2_addr", 64'(hm2_addr), 64'(m_addr));
      check("hm2_wdata", 64'(hm2_wdata), 64'(m_wdata));
      if (cyc == m_end) check("rdata", 64'(rdata), m_we ? 64'd0 : 64'(m_rdval));
      // HostMot2 stand-in: data valid only in the ReadLatency-th cycle counting the strobe cycle as 1.
      if (hm2_read) s_cnt = 1;
      else if (s_cnt > 0 && s_cnt < RL) s_cnt++;
      else s_cnt = 0;
      hm2_rdata = (s_cnt == RL) ? m_rdval : $urandom;
`ifdef HM2_ARB_LOCK_EN
      if (cyc == m_end && lock[m_owner]) m_locked = 1'b1;
      if (cyc > m_end && !(m_locked && lock[m_owner] && req[m_owner])) m_locked = 1'b0;
`endif
      if (cyc > m_end && req != 2'b00) begin
        if (m_locked) mw = m_owner;
        else if (req == 2'b11) mw = ~m_last;
        else mw = req[1];
        m_owner = mw;
        m_last  = mw;
        m_we    = we[mw];
        m_addr  = mw ? addr[2*AW-1:AW] : addr[AW-1:0];
        m_wdata = mw ? wdata[2*BW-1:BW] : wdata[BW-1:0];
        m_start = cyc;
        m_end   = cyc + (m_we ? 2 : RL + 1);
        if (!m_we) m_rdval = fix_rd ? fix_val : $urandom;
      end
    end
  end

  int   got [6];
  int   exp_order [6] = '{0, 1, 0, 1, 0, 1};
  int   k;
  logic [1:0] dropped = 2'b00;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_lit", 64'(busy), 64'd0);
    check("reset_ack_lit", 64'(ack), 64'd0);
    #1 rst = 1'b0;

    // Single write from requester 0.
    @(posedge clk); #1;
    req = 2'b01; we = 2'b01; addr = {16'h0000, 16'h0100}; wdata = {32'h0, 32'hDEADBEEF};
    @(posedge clk); #1;
    check("wr_strobe_lit", 64'(hm2_write), 64'd1);
    check("wr_addr_lit", 64'(hm2_addr), 64'h0100);
    check("wr_wdata_lit", 64'(hm2_wdata), 64'hDEADBEEF);
    check("wr_noack_lit", 64'(ack), 64'd0);
    @(posedge clk); #1;
    check("wr_ack_lit", 64'(ack), 64'd1);
    check("wr_strobe_off_lit", 64'(hm2_write), 64'd0);
    req = 2'b00;
    @(posedge clk); #1;
    check("wr_idle_lit", 64'(busy), 64'd0);

    // Single read from requester 1 with a fixed return value.
    fix_rd = 1'b1; fix_val = 32'h12345678;
    req = 2'b10; we = 2'b00; addr = {16'h0200, 16'h0000};
    @(posedge clk); #1;
    check("rd_strobe_lit", 64'(hm2_read), 64'd1);
    check("rd_addr_lit", 64'(hm2_addr), 64'h0200);
    @(posedge clk); #1;
    check("rd_strobe_once_lit", 64'(hm2_read), 64'd0);
    check("rd_noack_lit", 64'(ack), 64'd0);
    @(posedge clk); #1;
    check("rd_ack_lit", 64'(ack), 64'd2);
    check("rd_data_lit", 64'(rdata), 64'h12345678);
    req = 2'b00; fix_rd = 1'b0;
    @(posedge clk); #1;

    // Requester 0 pulses req for one cycle only.
    req = 2'b01; we = 2'b01; addr = {16'h0000, 16'h0042}; wdata = {32'h0, 32'hCAFEF00D};
    @(posedge clk); #1;
    req = 2'b00;
    check("drop_strobe_lit", 64'(hm2_write), 64'd1);
    @(posedge clk); #1;
    check("drop_ack_lit", 64'(ack), 64'd1);
    @(posedge clk); #1;
    check("drop_idle_lit", 64'(busy), 64'd0);

    // Reset while a read is waiting for data.
    req = 2'b01; we = 2'b00;
    @(posedge clk); #1;
    check("rst_rd_strobe_lit", 64'(hm2_read), 64'd1);
    check("rst_rd_busy_lit", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy_lit", 64'(busy), 64'd0);
    check("async_rst_read_lit", 64'(hm2_read), 64'd0);
    check("async_rst_ack_lit", 64'(ack), 64'd0);
    req = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Continuous tie: grants must alternate starting with requester 0.
    @(posedge clk); #1;
    req = 2'b11; we = 2'b00;
    k = 0;
    for (int t = 0; t < 60 && k < 6; t++) begin
      @(posedge clk); #1;
      if (ack != 2'b00) begin
        got[k] = int'(ack[1]);
        k++;
      end
    end
    req = 2'b00;
    check("tie_ack_count", 64'(k), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < k) check("tie_order", 64'(got[i]), 64'(exp_order[i]));
    end
    repeat (2) @(posedge clk);

    // Random traffic following the hold-until-ack protocol, with occasional owner drops.
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          dropped[i] = 1'b0;
        end else if (req[i]) begin
          if (int'(m_owner) == i && (cyc + 1 > m_start) && (cyc + 1 < m_end) && $urandom_range(0, 15) == 0) begin
            req[i] = 1'b0;
            dropped[i] = 1'b1;
          end
        end else if (!dropped[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      we    = 2'($urandom);
      addr  = 32'($urandom);
      wdata = {$urandom, $urandom};
`ifdef HM2_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = 2'($urandom);
`endif
    end
    req = 2'b00;
    repeat (20) @(posedge clk);
    #1;
    check("final_idle", 64'(busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
